// File: rtl/clk_rst_pkg.sv
// Shared types and helpers for the clock-enable / reset sequencer.
package clk_rst_pkg;

   // Sequencer states, in the order a clean power-up walks through them.
   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      HOLD      = 2'd1,
      RELEASE   = 2'd2,
      RUN       = 2'd3
   } state_t;

   // Width of the saturating reset-event counter.
   localparam int RESET_COUNT_WIDTH = 8;

   // Counter width able to hold value-1, never narrower than one bit.
   function automatic int clog2_min1(input int value);
      int w;
      w = $clog2(value);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/ce_divider.sv
// One clock-enable channel: divisor clamp, phase counter, hold while in reset.
module ce_divider #(
   parameter int DIV_WIDTH = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_en,
   input  logic [DIV_WIDTH-1:0] i_div,
   output logic                 o_ce
);

   localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

   logic [DIV_WIDTH-1:0] div_eff;
   logic [DIV_WIDTH-1:0] cnt_q;
   logic [DIV_WIDTH-1:0] cnt_d;
   logic                 ce_q;
   logic                 ce_d;

   // Count 0..D-1 and strobe on the wrap; a count at or past the new
   // terminal value (divisor lowered) strobes and wraps right away.
   always_comb begin
      div_eff = (i_div == '0) ? ONE : i_div;
      cnt_d   = '0;
      ce_d    = 1'b0;
      if (i_en) begin
         if (cnt_q >= (div_eff - ONE)) begin
            ce_d  = 1'b1;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + ONE;
         end
      end
   end

   // Counter and strobe registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q <= '0;
         ce_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ce_q  <= ce_d;
      end
   end

   // Gated so the strobe drops in the same cycle the enable is withdrawn.
   assign o_ce = ce_q & i_en;

endmodule

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into i_clk.
module sync_2ff (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic meta_q;
   logic sync_q;

   // Two back-to-back flops; both clear to 0 on reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= i_d;
         sync_q <= meta_q;
      end
   end

   assign o_q = sync_q;

endmodule

// File: rtl/clk_rst_manager.sv
// Reset sequencer and clock-enable generator for the FROST board top.
// Channel 0 of i_ce_div occupies the most-significant field, so a board
// top can write {div_ch0, div_ch1, ...}.
module clk_rst_manager
   import clk_rst_pkg::*;
#(
   parameter int NUM_CE_CHANNELS   = 2,
   parameter int CE_DIV_WIDTH      = 8,
   parameter int NUM_RESET_STAGES  = 3,
   parameter int RESET_HOLD_CYCLES = 16,
   parameter int STAGE_GAP_CYCLES  = 4,
   parameter int DEBOUNCE_CYCLES   = 1024
) (
   input  logic                                    i_clk,
   input  logic                                    i_rst_n,
   input  logic                                    i_locked,
   input  logic                                    i_button_n,
   input  logic [NUM_CE_CHANNELS*CE_DIV_WIDTH-1:0] i_ce_div,
   output logic [NUM_CE_CHANNELS-1:0]              o_ce,
   output logic [NUM_RESET_STAGES-1:0]             o_rst_n,
   output logic                                    o_ready,
   output logic [RESET_COUNT_WIDTH-1:0]            o_reset_count,
   output logic [1:0]                              o_state
);

   localparam int SEQ_MAX = (RESET_HOLD_CYCLES > STAGE_GAP_CYCLES) ?
                            RESET_HOLD_CYCLES : STAGE_GAP_CYCLES;
   localparam int CNT_W   = clog2_min1(SEQ_MAX);
   localparam int STAGE_W = clog2_min1(NUM_RESET_STAGES);
   localparam int DEB_W   = clog2_min1(DEBOUNCE_CYCLES);

   localparam logic [CNT_W-1:0]            HOLD_LAST  = CNT_W'(RESET_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]            GAP_LAST   = CNT_W'(STAGE_GAP_CYCLES - 1);
   localparam logic [STAGE_W-1:0]          STAGE_LAST = STAGE_W'(NUM_RESET_STAGES - 1);
   localparam logic [DEB_W-1:0]            DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [NUM_RESET_STAGES-1:0] STAGE0     = NUM_RESET_STAGES'(1);
   localparam logic [RESET_COUNT_WIDTH-1:0] COUNT_ONE = RESET_COUNT_WIDTH'(1);

   logic lock_sync;
   logic btn_sync;

   logic             db_q, db_d;       // debounced button, 1 = released
   logic [DEB_W-1:0] dcnt_q, dcnt_d;

   state_t                         state_q, state_d;
   logic [CNT_W-1:0]               cnt_q, cnt_d;
   logic [STAGE_W-1:0]             stage_q, stage_d;
   logic [NUM_RESET_STAGES-1:0]    rst_q, rst_d;
   logic                           ready_q, ready_d;
   logic [RESET_COUNT_WIDTH-1:0]   count_q, count_d;
   logic                           abort;

   sync_2ff u_lock_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_locked),
      .o_q     (lock_sync)
   );

   sync_2ff u_btn_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_button_n),
      .o_q     (btn_sync)
   );

   // Debounce: count consecutive cycles the input disagrees with the
   // debounced state; flip once that run reaches DEBOUNCE_CYCLES.
   always_comb begin
      db_d   = db_q;
      dcnt_d = '0;
      if (btn_sync != db_q) begin
         if (dcnt_q == DEB_LAST) begin
            db_d = btn_sync;
         end else begin
            dcnt_d = dcnt_q + DEB_W'(1);
         end
      end
   end

   // Any in-service state aborts on lock loss or a debounced press;
   // both at once are a single event.
   assign abort = (state_q != WAIT_LOCK) && (!lock_sync || !db_q);

   // Sequencer next state, registered resets, ready and event count.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stage_d = stage_q;
      rst_d   = rst_q;
      ready_d = ready_q;
      count_d = count_q;
      case (state_q)
         WAIT_LOCK: begin
            rst_d   = '0;
            ready_d = 1'b0;
            cnt_d   = '0;
            stage_d = '0;
            if (lock_sync && db_q) begin
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               cnt_d   = '0;
               rst_d   = STAGE0;
               stage_d = STAGE_W'(1);
               if (NUM_RESET_STAGES == 1) begin
                  state_d = RUN;
                  ready_d = 1'b1;
               end else begin
                  state_d = RELEASE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RELEASE: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               rst_d   = rst_q | (STAGE0 << stage_q);
               stage_d = stage_q + STAGE_W'(1);
               if (stage_q == STAGE_LAST) begin
                  state_d = RUN;
                  ready_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RUN: begin
            ready_d = 1'b1;
         end
         default: begin
            state_d = WAIT_LOCK;
         end
      endcase
      if (abort) begin
         state_d = WAIT_LOCK;
         rst_d   = '0;
         ready_d = 1'b0;
         cnt_d   = '0;
         stage_d = '0;
         if (count_q != '1) begin
            count_d = count_q + COUNT_ONE;
         end
      end
   end

   // All sequencer and debounce state registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= WAIT_LOCK;
         cnt_q   <= '0;
         stage_q <= '0;
         rst_q   <= '0;
         ready_q <= 1'b0;
         count_q <= '0;
         db_q    <= 1'b1;
         dcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stage_q <= stage_d;
         rst_q   <= rst_d;
         ready_q <= ready_d;
         count_q <= count_d;
         db_q    <= db_d;
         dcnt_q  <= dcnt_d;
      end
   end

   for (genvar g = 0; g < NUM_CE_CHANNELS; g++) begin : g_ce
      localparam int SLICE_LSB = (NUM_CE_CHANNELS - 1 - g) * CE_DIV_WIDTH;
      ce_divider #(
         .DIV_WIDTH (CE_DIV_WIDTH)
      ) u_ce_divider (
         .i_clk   (i_clk),
         .i_rst_n (i_rst_n),
         .i_en    (rst_q[0]),
         .i_div   (i_ce_div[SLICE_LSB +: CE_DIV_WIDTH]),
         .o_ce    (o_ce[g])
      );
   end

   assign o_rst_n       = rst_q;
   assign o_ready       = ready_q;
   assign o_reset_count = count_q;
   assign o_state       = state_q;

endmodule

// File: doc/clk_rst_manager.md
# clk_rst_manager

Parametrised clock-enable and reset sequencer for Xilinx FROST board tops. It sits between the board's MMCM/clock buffers and the FROST subsystem, in the main clock domain. It takes over the fixed divide-by-N clock products and the tied-off reset: it supervises MMCM lock and an optional push-button, releases a configurable number of reset stages in order, and generates N independently programmable clock-enable strobes.

## Interface
Parameters:
- NUM_CE_CHANNELS, 2, number of clock-enable outputs
- CE_DIV_WIDTH, 8, width of each divide-ratio input
- NUM_RESET_STAGES, 3, number of sequenced reset outputs; stage 0 is released first
- RESET_HOLD_CYCLES, 16, cycles all resets stay asserted after lock is seen
- STAGE_GAP_CYCLES, 4, cycles between consecutive stage releases
- DEBOUNCE_CYCLES, 1024, cycles the button must be stable for its debounced state to change

Ports:
- i_clk  in  1  main clock; every register is in this domain
- i_rst_n  in  1  asynchronous, active-low reset
- i_locked  in  1  MMCM LOCKED, asynchronous; passes through an internal 2-FF synchronizer
- i_button_n  in  1  push-button, active-low, asynchronous; 2-FF synchronizer, then debounce; boards without a button tie it to 1
- i_ce_div  in  NUM_CE_CHANNELS×CE_DIV_WIDTH  divide ratio per channel, quasi-static
- o_ce  out  NUM_CE_CHANNELS  one-cycle clock-enable strobes
- o_rst_n  out  NUM_RESET_STAGES  active-low synchronous-release resets, registered
- o_ready  out  1  high only in RUN
- o_reset_count  out  8  saturating count of in-service reset events

## Operation
- States: WAIT_LOCK, HOLD, RELEASE, RUN.
- WAIT_LOCK: all o_rst_n low. Move to HOLD when lock_sync=1 and the debounced button is released.
- HOLD: counts RESET_HOLD_CYCLES cycles with all resets low, then enters RELEASE.
- RELEASE: o_rst_n[0] rises on entry. o_rst_n[k] rises STAGE_GAP_CYCLES cycles after o_rst_n[k-1]. After the last stage rises, enter RUN.
- RUN: o_ready=1.
- Abort: in HOLD, RELEASE or RUN, lock_sync=0 or a debounced press causes the next edge to go to WAIT_LOCK and drive all o_rst_n and o_ready low in the same cycle.
  - o_reset_count increments on abort and saturates at 255.
  - If both causes occur together, this counts as one event.
- Debounce: a counter restarts whenever the synchronized button differs from the debounced state. The debounced state flips when the count reaches DEBOUNCE_CYCLES.
- CE channel i has an effective divisor D = max(i_ce_div[i], 1).
  - An internal counter runs 0..D-1, and o_ce[i]=1 when the count is D-1.
  - D=1 gives o_ce held high.
  - While o_rst_n[0]=0, the counter is held at 0 and o_ce=0. This aligns the phase of all channels at release.
  - If D changes so that count ≥ D-1, o_ce fires on the next cycle and the counter wraps to 0. No strobe is skipped indefinitely.

## Timing
- Reset values (i_rst_n=0): o_rst_n all 0, o_ce all 0, o_ready=0, o_reset_count=0, state WAIT_LOCK, debounced button = released, synchronizers at 0.
- With i_locked=1 and i_button_n=1 before i_rst_n rises:
  - lock_sync is high after 2 edges.
  - HOLD is entered at edge 3.
  - o_rst_n[0] rises at edge 3+RESET_HOLD_CYCLES (edge 19 with defaults).
  - o_rst_n[k] rises at edge 19+4k.
  - o_ready rises with the last stage (edge 27).
- Abort latency: lock-loss to o_rst_n low is 3 edges (2 sync + 1 registered).
- i_rst_n is asynchronous and may assert mid-sequence. All outputs go to their reset values immediately.
- CE: the first o_ce[i] pulse is D cycles after o_rst_n[0] rises. Pulses then repeat every D cycles.

## Structure
- Package clk_rst_pkg holds the state enum (WAIT_LOCK, HOLD, RELEASE, RUN) and the 8-bit reset-count width localparam.
- Counter widths are derived with $clog2 of the respective parameters, with a minimum width of 1.
- Sub-module ce_divider (one CE channel: counter, divisor clamp, hold-while-reset) is instantiated NUM_CE_CHANNELS times in a generate loop.
- The synchronizers use the codebase's existing 2-FF synchronizer module.

## Test plan
Bench defaults: DEBOUNCE_CYCLES overridden to 8.
- Power-up: i_locked=1, i_button_n=1, release i_rst_n → o_rst_n = 3'b001 at edge 19, 3'b011 at edge 23, 3'b111 and o_ready=1 at edge 27.
- Lock loss in RUN: drop i_locked for 1 cycle → o_rst_n=0 and o_ready=0 3 edges later. o_reset_count=1. The full sequence repeats once lock_sync returns.
- Debounce: 5-cycle low glitch on i_button_n → no effect. 20-cycle press → abort after 2 sync + 8 debounce cycles. Resequence begins only after 8 stable released cycles.
- CE: i_ce_div={8'd4, 8'd0} → ch0 pulses first at 4 cycles after o_rst_n[0] rises, then every 4 cycles. ch1 is constantly high after release.
- Divisor change: ch0 D=10 at count 7, set to 4 → strobe the next cycle, then period 4.
- Saturation and async reset: 300 lock drops → o_reset_count=255. Assert i_rst_n mid-RELEASE → all outputs 0 without waiting for a clock edge.
